// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: default widths, the
// hard-wired zero register and the registered control bundle.
package ex_operand_stage_pkg;

    localparam int N_DEF     = 32;
    localparam int RAW_DEF   = 5;
    localparam int IMM_W_DEF = 16;

    // Register $0 is hard-wired to zero and never takes part in forwarding.
    localparam int REG_ZERO  = 0;

    typedef struct packed {
        logic valid;
        logic add_n;
        logic add_slt;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic alu_src_imm;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Forwarding select for one source register: the EX/MEM result wins over the
// MEM/WB result, which wins over the value captured at decode.
module ex_operand_stage_fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int RAW = RAW_DEF
) (
    input  logic [RAW-1:0] src,
    input  logic [N-1:0]   stored,
    input  logic           exmem_we,
    input  logic [RAW-1:0] exmem_dst,
    input  logic [N-1:0]   exmem_data,
    input  logic           memwb_we,
    input  logic [RAW-1:0] memwb_dst,
    input  logic [N-1:0]   memwb_data,
    output logic [N-1:0]   value
);

    logic hit_exmem;
    logic hit_memwb;

    assign hit_exmem = exmem_we && (exmem_dst != RAW'(REG_ZERO)) && (exmem_dst == src);
    assign hit_memwb = memwb_we && (memwb_dst != RAW'(REG_ZERO)) && (memwb_dst == src);

    // Priority select: younger producer first.
    always_comb begin
        value = stored;
        if (hit_exmem) begin
            value = exmem_data;
        end else if (hit_memwb) begin
            value = memwb_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble
// insertion, feeding the EX-stage arithmetic unit.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int RAW   = RAW_DEF,
    parameter int IMM_W = IMM_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           stall_i,
    input  logic           flush_i,
    input  logic           id_valid_i,
    input  logic [RAW-1:0] id_rs_i,
    input  logic [RAW-1:0] id_rt_i,
    input  logic [RAW-1:0] id_dst_i,
    input  logic           id_uses_rs_i,
    input  logic           id_uses_rt_i,
    input  logic [N-1:0]   id_rs_val_i,
    input  logic [N-1:0]   id_rt_val_i,
    input  logic [IMM_W-1:0] id_imm_i,
    input  logic           id_alu_src_imm_i,
    input  logic           id_imm_zext_i,
    input  logic           id_add_n_i,
    input  logic           id_add_slt_i,
    input  logic           id_reg_write_i,
    input  logic           id_mem_read_i,
    input  logic           id_mem_write_i,
    input  logic           exmem_we_i,
    input  logic [RAW-1:0] exmem_dst_i,
    input  logic [N-1:0]   exmem_data_i,
    input  logic           memwb_we_i,
    input  logic [RAW-1:0] memwb_dst_i,
    input  logic [N-1:0]   memwb_data_i,
    output logic           load_use_stall_o,
    output logic [N-1:0]   A_o,
    output logic [N-1:0]   B_o,
    output logic           add_n_o,
    output logic           add_slt_o,
    output logic [N-1:0]   store_data_o,
    output logic [RAW-1:0] ex_dst_o,
    output logic           ex_valid_o,
    output logic           ex_reg_write_o,
    output logic           ex_mem_read_o,
    output logic           ex_mem_write_o
);

    ctrl_t          ctrl_q;
    ctrl_t          ctrl_d;
    logic [RAW-1:0] rs_q;
    logic [RAW-1:0] rt_q;
    logic [RAW-1:0] dst_q;
    logic [N-1:0]   rs_val_q;
    logic [N-1:0]   rt_val_q;
    logic [N-1:0]   imm_q;
    logic [N-1:0]   imm_ext;
    logic [N-1:0]   fwd_rs;
    logic [N-1:0]   fwd_rt;
    logic           rs_dep;
    logic           rt_dep;

    ex_operand_stage_fwd_mux #(.N(N), .RAW(RAW)) u_fwd_rs (
        .src        (rs_q),
        .stored     (rs_val_q),
        .exmem_we   (exmem_we_i),
        .exmem_dst  (exmem_dst_i),
        .exmem_data (exmem_data_i),
        .memwb_we   (memwb_we_i),
        .memwb_dst  (memwb_dst_i),
        .memwb_data (memwb_data_i),
        .value      (fwd_rs)
    );

    ex_operand_stage_fwd_mux #(.N(N), .RAW(RAW)) u_fwd_rt (
        .src        (rt_q),
        .stored     (rt_val_q),
        .exmem_we   (exmem_we_i),
        .exmem_dst  (exmem_dst_i),
        .exmem_data (exmem_data_i),
        .memwb_we   (memwb_we_i),
        .memwb_dst  (memwb_dst_i),
        .memwb_data (memwb_data_i),
        .value      (fwd_rt)
    );

    // A load in EX whose destination is read by the decode slot must be
    // separated by one bubble; a global stall already holds everything.
    assign rs_dep = id_uses_rs_i && (id_rs_i == dst_q);
    assign rt_dep = id_uses_rt_i && (id_rt_i == dst_q);
    assign load_use_stall_o = ctrl_q.valid && ctrl_q.mem_read && (dst_q != RAW'(REG_ZERO))
                              && (rs_dep || rt_dep) && id_valid_i && !stall_i;

    // Immediate is widened at capture so EX sees a ready-made operand.
    assign imm_ext = {{(N-IMM_W){id_imm_i[IMM_W-1] & ~id_imm_zext_i}}, id_imm_i};

    // Pack decode control into the stored bundle.
    always_comb begin
        ctrl_d             = CTRL_BUBBLE;
        ctrl_d.valid       = id_valid_i;
        ctrl_d.add_n       = id_add_n_i;
        ctrl_d.add_slt     = id_add_slt_i;
        ctrl_d.reg_write   = id_reg_write_i;
        ctrl_d.mem_read    = id_mem_read_i;
        ctrl_d.mem_write   = id_mem_write_i;
        ctrl_d.alu_src_imm = id_alu_src_imm_i;
    end

    // Stage register: flush > stall > load-use bubble > capture. During a
    // stall the operand values absorb any forwarded result so a producer
    // that retires while we wait is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= CTRL_BUBBLE;
            rs_q     <= '0;
            rt_q     <= '0;
            dst_q    <= '0;
            rs_val_q <= '0;
            rt_val_q <= '0;
            imm_q    <= '0;
        end else if (flush_i || (!stall_i && load_use_stall_o)) begin
            ctrl_q   <= CTRL_BUBBLE;
            rs_q     <= '0;
            rt_q     <= '0;
            dst_q    <= '0;
            rs_val_q <= '0;
            rt_val_q <= '0;
            imm_q    <= '0;
        end else if (stall_i) begin
            rs_val_q <= fwd_rs;
            rt_val_q <= fwd_rt;
        end else begin
            ctrl_q   <= ctrl_d;
            rs_q     <= id_rs_i;
            rt_q     <= id_rt_i;
            dst_q    <= id_dst_i;
            rs_val_q <= id_rs_val_i;
            rt_val_q <= id_rt_val_i;
            imm_q    <= imm_ext;
        end
    end

    assign A_o            = fwd_rs;
    assign store_data_o   = fwd_rt;
    assign B_o            = ctrl_q.alu_src_imm ? imm_q : fwd_rt;
    assign add_n_o        = ctrl_q.add_n;
    assign add_slt_o      = ctrl_q.add_slt;
    assign ex_dst_o       = dst_q;
    assign ex_valid_o     = ctrl_q.valid;
    assign ex_reg_write_o = ctrl_q.reg_write;
    assign ex_mem_read_o  = ctrl_q.mem_read;
    assign ex_mem_write_o = ctrl_q.mem_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the stage.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i, id_valid_i;
    logic [4:0]  id_rs_i, id_rt_i, id_dst_i;
    logic        id_uses_rs_i, id_uses_rt_i;
    logic [31:0] id_rs_val_i, id_rt_val_i;
    logic [15:0] id_imm_i;
    logic        id_alu_src_imm_i, id_imm_zext_i, id_add_n_i, id_add_slt_i;
    logic        id_reg_write_i, id_mem_read_i, id_mem_write_i;
    logic        exmem_we_i, memwb_we_i;
    logic [4:0]  exmem_dst_i, memwb_dst_i;
    logic [31:0] exmem_data_i, memwb_data_i;
    logic        load_use_stall_o;
    logic [31:0] A_o, B_o, store_data_o;
    logic        add_n_o, add_slt_o;
    logic [4:0]  ex_dst_o;
    logic        ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o;

    int n_checks = 0;
    int n_errors = 0;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_dst_i(id_dst_i),
        .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
        .id_rs_val_i(id_rs_val_i), .id_rt_val_i(id_rt_val_i), .id_imm_i(id_imm_i),
        .id_alu_src_imm_i(id_alu_src_imm_i), .id_imm_zext_i(id_imm_zext_i),
        .id_add_n_i(id_add_n_i), .id_add_slt_i(id_add_slt_i),
        .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
        .exmem_we_i(exmem_we_i), .exmem_dst_i(exmem_dst_i), .exmem_data_i(exmem_data_i),
        .memwb_we_i(memwb_we_i), .memwb_dst_i(memwb_dst_i), .memwb_data_i(memwb_data_i),
        .load_use_stall_o(load_use_stall_o), .A_o(A_o), .B_o(B_o),
        .add_n_o(add_n_o), .add_slt_o(add_slt_o), .store_data_o(store_data_o),
        .ex_dst_o(ex_dst_o), .ex_valid_o(ex_valid_o), .ex_reg_write_o(ex_reg_write_o),
        .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o)
    );

    always #5 clk = ~clk;

    // Model of what the stage currently holds.
    logic        m_valid, m_rw, m_mr, m_mw, m_addn, m_slt, m_use_imm;
    logic [4:0]  m_rs, m_rt, m_dst;
    logic [31:0] m_rsv, m_rtv, m_imm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] v);
        if (r == 5'd0) return v;
        if (exmem_we_i && exmem_dst_i == r) return exmem_data_i;
        if (memwb_we_i && memwb_dst_i == r) return memwb_data_i;
        return v;
    endfunction

    function automatic logic m_load_use();
        logic reads;
        reads = (id_uses_rs_i && id_rs_i == m_dst) || (id_uses_rt_i && id_rt_i == m_dst);
        return m_valid && m_mr && m_dst != 5'd0 && id_valid_i && !stall_i && reads;
    endfunction

    task automatic model_clear();
        {m_valid, m_rw, m_mr, m_mw, m_addn, m_slt, m_use_imm} = '0;
        m_rs = '0; m_rt = '0; m_dst = '0;
        m_rsv = '0; m_rtv = '0; m_imm = '0;
    endtask

    // Apply one clock edge to the model, using the inputs seen at that edge.
    task automatic model_edge(input logic lu);
        logic [31:0] nrs, nrt;
        nrs = m_fwd(m_rs, m_rsv);
        nrt = m_fwd(m_rt, m_rtv);
        if (!rst_n || flush_i) begin
            model_clear();
        end else if (stall_i) begin
            m_rsv = nrs;
            m_rtv = nrt;
        end else if (lu) begin
            model_clear();
        end else begin
            m_valid = id_valid_i; m_rw = id_reg_write_i; m_mr = id_mem_read_i;
            m_mw = id_mem_write_i; m_addn = id_add_n_i; m_slt = id_add_slt_i;
            m_use_imm = id_alu_src_imm_i;
            m_rs = id_rs_i; m_rt = id_rt_i; m_dst = id_dst_i;
            m_rsv = id_rs_val_i; m_rtv = id_rt_val_i;
            m_imm = id_imm_zext_i ? {16'h0000, id_imm_i} : {{16{id_imm_i[15]}}, id_imm_i};
        end
    endtask

    task automatic check_all();
        logic [31:0] ea, es;
        ea = m_fwd(m_rs, m_rsv);
        es = m_fwd(m_rt, m_rtv);
        check("load_use", load_use_stall_o, m_load_use());
        check("A", A_o, ea);
        check("B", B_o, m_use_imm ? m_imm : es);
        check("store_data", store_data_o, es);
        check("add_n", add_n_o, m_addn);
        check("add_slt", add_slt_o, m_slt);
        check("dst", ex_dst_o, m_dst);
        check("valid", ex_valid_o, m_valid);
        check("reg_write", ex_reg_write_o, m_rw);
        check("mem_read", ex_mem_read_o, m_mr);
        check("mem_write", ex_mem_write_o, m_mw);
    endtask

    // Called just after a falling edge with inputs settled: check, clock, advance model.
    task automatic step();
        logic lu;
        #1;
        check_all();
        lu = m_load_use();
        @(posedge clk);
        model_edge(lu);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall_i = 0; flush_i = 0; id_valid_i = 0;
        id_rs_i = 0; id_rt_i = 0; id_dst_i = 0; id_uses_rs_i = 0; id_uses_rt_i = 0;
        id_rs_val_i = 0; id_rt_val_i = 0; id_imm_i = 0;
        id_alu_src_imm_i = 0; id_imm_zext_i = 0; id_add_n_i = 0; id_add_slt_i = 0;
        id_reg_write_i = 0; id_mem_read_i = 0; id_mem_write_i = 0;
        exmem_we_i = 0; exmem_dst_i = 0; exmem_data_i = 0;
        memwb_we_i = 0; memwb_dst_i = 0; memwb_data_i = 0;
    endtask

    task automatic decode_rr(input logic [4:0] rs, input logic [31:0] rsv,
                             input logic [4:0] rt, input logic [31:0] rtv, input logic [4:0] dst);
        id_valid_i = 1; id_rs_i = rs; id_rt_i = rt; id_dst_i = dst;
        id_uses_rs_i = 1; id_uses_rt_i = 1; id_rs_val_i = rsv; id_rt_val_i = rtv;
        id_alu_src_imm_i = 0; id_reg_write_i = 1; id_mem_read_i = 0; id_mem_write_i = 0;
        id_add_n_i = 0; id_add_slt_i = 0;
    endtask

    initial begin
        idle_inputs();
        model_clear();
        rst_n = 0;
        exmem_we_i = 1; exmem_dst_i = 5'd1; exmem_data_i = 32'h1111_1111;
        decode_rr(5'd1, 32'h5, 5'd1, 32'h7, 5'd3);
        repeat (2) @(negedge clk);
        #1;
        check("rst_A", A_o, 32'h0);
        check("rst_valid", ex_valid_o, 1'b0);
        check("rst_load_use", load_use_stall_o, 1'b0);
        step();

        // Plain register-register add.
        rst_n = 1;
        idle_inputs();
        decode_rr(5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
        step();
        idle_inputs();
        #1;
        check("add_A", A_o, 32'd5);
        check("add_B", B_o, 32'd7);
        check("add_n0", add_n_o, 1'b0);
        check("add_valid", ex_valid_o, 1'b1);

        // EX/MEM beats MEM/WB; MEM/WB used once EX/MEM drops out.
        decode_rr(5'd3, 32'h99, 5'd2, 32'd7, 5'd6);
        step();
        exmem_we_i = 1; exmem_dst_i = 5'd3; exmem_data_i = 32'h10;
        memwb_we_i = 1; memwb_dst_i = 5'd3; memwb_data_i = 32'h20;
        #1 check("fwd_exmem", A_o, 32'h10);
        exmem_we_i = 0;
        #1 check("fwd_memwb", A_o, 32'h20);
        idle_inputs();

        // lw $4 in EX, consumer reads $4 through rt.
        decode_rr(5'd1, 32'd1, 5'd0, 32'd0, 5'd4);
        id_mem_read_i = 1;
        step();
        decode_rr(5'd1, 32'd1, 5'd4, 32'd0, 5'd7);
        #1 check("lu_assert", load_use_stall_o, 1'b1);
        step();
        #1;
        check("lu_bubble_valid", ex_valid_o, 1'b0);
        check("lu_bubble_rw", ex_reg_write_o, 1'b0);
        check("lu_bubble_A", A_o, 32'h0);

        // Immediate extension.
        idle_inputs();
        decode_rr(5'd1, 32'd1, 5'd2, 32'd2, 5'd8);
        id_imm_i = 16'hFFFF; id_alu_src_imm_i = 1; id_imm_zext_i = 0;
        step();
        #1 check("imm_sext", B_o, 32'hFFFF_FFFF);
        id_imm_zext_i = 1;
        step();
        #1 check("imm_zext", B_o, 32'h0000_FFFF);

        // Stall for 3 cycles while $5 retires from MEM/WB in the second.
        idle_inputs();
        decode_rr(5'd5, 32'h0, 5'd2, 32'd2, 5'd9);
        step();
        idle_inputs();
        stall_i = 1;
        step();
        memwb_we_i = 1; memwb_dst_i = 5'd5; memwb_data_i = 32'h55;
        step();
        memwb_we_i = 0;
        #1 check("stall_keep", A_o, 32'h55);
        step();
        stall_i = 0;
        #1 check("stall_release", A_o, 32'h55);

        // $0 never forwards.
        decode_rr(5'd0, 32'h0, 5'd2, 32'd2, 5'd9);
        step();
        idle_inputs();
        exmem_we_i = 1; exmem_dst_i = 5'd0; exmem_data_i = 32'hDEAD;
        #1 check("zero_nofwd", A_o, 32'h0);

        // Flush together with stall loads a bubble.
        flush_i = 1; stall_i = 1;
        step();
        idle_inputs();
        #1;
        check("flush_valid", ex_valid_o, 1'b0);
        check("flush_A", A_o, 32'h0);
        check("flush_B", B_o, 32'h0);

        // Reset asserted in the middle of a stall.
        decode_rr(5'd2, 32'hAB, 5'd3, 32'hCD, 5'd10);
        step();
        stall_i = 1;
        step();
        #2 rst_n = 0;
        #1;
        check("midrst_valid", ex_valid_o, 1'b0);
        check("midrst_A", A_o, 32'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1; stall_i = 0;
        decode_rr(5'd2, 32'h12, 5'd3, 32'h34, 5'd11);
        step();
        #1;
        check("postrst_valid", ex_valid_o, 1'b1);
        check("postrst_A", A_o, 32'h12);

        // Randomized traffic with a small register window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            stall_i          = ($urandom_range(0, 99) < 15);
            flush_i          = ($urandom_range(0, 99) < 7);
            id_valid_i       = ($urandom_range(0, 99) < 85);
            id_rs_i          = 5'($urandom_range(0, 7));
            id_rt_i          = 5'($urandom_range(0, 7));
            id_dst_i         = 5'($urandom_range(0, 7));
            id_uses_rs_i     = 1'($urandom);
            id_uses_rt_i     = 1'($urandom);
            id_rs_val_i      = $urandom;
            id_rt_val_i      = $urandom;
            id_imm_i         = 16'($urandom);
            id_alu_src_imm_i = 1'($urandom);
            id_imm_zext_i    = 1'($urandom);
            id_add_n_i       = 1'($urandom);
            id_add_slt_i     = 1'($urandom);
            id_reg_write_i   = 1'($urandom);
            id_mem_read_i    = ($urandom_range(0, 99) < 40);
            id_mem_write_i   = 1'($urandom);
            exmem_we_i       = 1'($urandom);
            exmem_dst_i      = 5'($urandom_range(0, 7));
            exmem_data_i     = $urandom;
            memwb_we_i       = 1'($urandom);
            memwb_dst_i      = 5'($urandom_range(0, 7));
            memwb_data_i     = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register and operand-selection stage sitting directly upstream of the EX-stage arithmetic unit. Captures decoded operands and control from decode and resolves EX/MEM and MEM/WB forwarding. Drives the arithmetic unit's A, B, add_n and add_slt inputs. Detects load-use hazards and inserts bubbles, honouring pipeline stall and flush.

Parameters:
N, 32, datapath width
RAW, 5, register-address width
IMM_W, 16, raw immediate width (N > IMM_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
stall_i  in  1  downstream/global stall; hold stage contents
flush_i  in  1  squash instruction being captured (branch/exception)
id_valid_i  in  1  decode slot holds a real instruction
id_rs_i, id_rt_i, id_dst_i  in  RAW each  source/destination register numbers
id_uses_rs_i, id_uses_rt_i  in  1 each  instruction reads rs/rt
id_rs_val_i, id_rt_val_i  in  N each  register-file read data
id_imm_i  in  IMM_W  raw immediate
id_alu_src_imm_i, id_imm_zext_i  in  1 each  B = immediate; zero- vs sign-extend
id_add_n_i, id_add_slt_i  in  1 each  subtract / set-less-than select
id_reg_write_i, id_mem_read_i, id_mem_write_i  in  1 each  downstream control
exmem_we_i  in  1  EX/MEM writes a register
exmem_dst_i  in  RAW  EX/MEM destination
exmem_data_i  in  N  EX/MEM result
memwb_we_i  in  1  MEM/WB writes a register
memwb_dst_i  in  RAW  MEM/WB destination
memwb_data_i  in  N  MEM/WB result
load_use_stall_o  out  1  hold PC and IF/ID this cycle
A_o, B_o  out  N each  arithmetic-unit operands
add_n_o, add_slt_o  out  1 each  arithmetic-unit controls
store_data_o  out  N  forwarded rt value for stores
ex_dst_o  out  RAW  destination register
ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o  out  1 each  EX-stage control

Behaviour:
- Reset (rst_n low, async): every stage register is cleared to 0. All outputs are 0, and load_use_stall_o is 0 while held in reset.
- Latency: 1 cycle. Decode fields are captured on the rising edge and appear on outputs the same cycle they are registered.
- Load-use detection (combinational): load_use_stall_o = ex_valid & ex_mem_read & ex_dst != 0 & ((id_uses_rs & id_rs == ex_dst) | (id_uses_rt & id_rt == ex_dst)) & id_valid_i. It is never asserted during stall_i.
- Per-edge update, in priority order:
  - flush_i: load a bubble. valid, reg_write, mem_read, mem_write, add_n and add_slt become 0; data fields become 0.
  - stall_i: hold all control and register fields. The stored rs/rt values are rewritten with the current forwarded values so that a producer retiring during the stall is not lost.
  - load_use_stall_o: load a bubble.
  - Otherwise: capture the decode fields. The immediate is extended to N bits (zero-extended if imm_zext, else sign-extended) and stored extended.
- Forwarding (combinational from stored fields), per source register r with stored value v:
  - If exmem_we & exmem_dst != 0 & exmem_dst == r, use exmem_data.
  - Else if memwb_we & memwb_dst != 0 & memwb_dst == r, use memwb_data.
  - Else use v.
  - Register 0 never forwards. EX/MEM has priority over MEM/WB.
- Operand outputs:
  - A_o = fwd(rs).
  - store_data_o = fwd(rt).
  - B_o = alu_src_imm ? ext_imm : fwd(rt).
  - add_n_o and add_slt_o are the stored values.
- Bubble outputs: a bubble drives ex_valid_o = 0 and A_o = B_o = 0, apart from forwarding on register 0, which never matches.
- Simultaneous flush_i and stall_i: flush wins.
- Reset asserted mid-stall: clears immediately. The first edge after rst_n rises captures normally.

Decomposition:
- Shared package: N/RAW/IMM_W defaults, a REG_ZERO constant, and a control-bundle typedef (add_n, add_slt, reg_write, mem_read, mem_write, alu_src_imm, valid).
- One natural sub-module: fwd_mux (dst compare plus priority select), instantiated twice, for rs and rt.

Test Plan:
- Reset, then decode add with rs=$1 (val 5), rt=$2 (val 7), no hazards → next cycle A_o=5, B_o=7, add_n_o=0, ex_valid_o=1.
- Capture with rs=$3 while exmem_we=1, exmem_dst=3, exmem_data=0x10 and memwb_dst=3, memwb_data=0x20 → A_o=0x10. Drop exmem_we → A_o=0x20.
- EX holds lw $4 (mem_read=1) and decode reads rt=$4 → load_use_stall_o=1 in that cycle. Next cycle ex_valid_o=0 and ex_reg_write_o=0.
- Immediate 0xFFFF with alu_src_imm=1: imm_zext=0 → B_o=0xFFFFFFFF; imm_zext=1 → B_o=0x0000FFFF.
- Stall_i held 3 cycles while memwb writes $5=0x55 in cycle 2, instruction reading rs=$5 with stale value 0 → after stall releases, A_o stays 0x55.
- Forward from $0 (exmem_dst=0, data 0xDEAD) → A_o = stored value 0. flush_i and stall_i both asserted → bubble loaded.
